// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

  // Wide all-ones pattern; users slice it down to their own width.
  localparam logic [63:0] SAT_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem_i, bit_i};
  assign fits    = (shifted >= {1'b0, divisor_i});

  // Because rem_i < divisor_i, a fitting difference always fits in WIDTH bits,
  // so only the low bits of the subtraction are needed.
  always_comb begin
    q_bit_o = fits;
    if (fits) begin
      rem_o = shifted[WIDTH-1:0] - divisor_i;
    end else begin
      rem_o = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor with
// valid/ready handshakes and divide-by-zero / quotient-overflow detection.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [2*WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o,
  output logic               div0_o,
  output logic               ovf_o
);

  localparam logic [WIDTH-1:0] QUOT_SAT = SAT_ONES[WIDTH-1:0];
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (shq_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    shq_d       = shq_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          in_ready_d = 1'b0;
          dvs_d      = divisor_i;
          if (divisor_i == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = QUOT_SAT;
            remainder_d = dividend_i[WIDTH-1:0];
            div0_d      = 1'b1;
            ovf_d       = 1'b0;
          end else if (dividend_i[2*WIDTH-1:WIDTH] >= divisor_i) begin
            // The quotient would need more than WIDTH bits.
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = QUOT_SAT;
            remainder_d = '0;
            div0_d      = 1'b0;
            ovf_d       = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = dividend_i[2*WIDTH-1:WIDTH];
            shq_d   = dividend_i[WIDTH-1:0];
            cnt_d   = '0;
          end
        end
      end

      RUN: begin
        rem_d = step_rem;
        shq_d = {shq_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = {shq_q[WIDTH-2:0], step_bit};
          remainder_d = step_rem;
          div0_d      = 1'b0;
          ovf_d       = 1'b0;
        end
      end

      DONE: begin
        if (out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      shq_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      shq_q       <= shq_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div0_o      = div0_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] dividend_i;
  logic [7:0]  divisor_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  quotient_o;
  logic [7:0]  remainder_o;
  logic        div0_o;
  logic        ovf_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div0_o      (div0_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  exp_q;
    logic [7:0]  exp_r;
    logic        exp_div0;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one operation, wait (bounded) for the result, check it, then take it.
  task automatic do_op(input vec_t v);
    int edges;
    check("ready_before_op", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    dividend_i = v.dividend;
    divisor_i  = v.divisor;
    tick();
    in_valid_i = 1'b0;
    edges = 1;
    while (!out_valid_o && edges < 20) begin
      tick();
      edges++;
    end
    check("latency", 32'(edges), 32'(v.exp_lat));
    check("quotient", 32'(quotient_o), 32'(v.exp_q));
    check("remainder", 32'(remainder_o), 32'(v.exp_r));
    check("div0", 32'(div0_o), 32'(v.exp_div0));
    check("ovf", 32'(ovf_o), 32'(v.exp_ovf));
    check("ready_low_in_done", 32'(in_ready_o), 32'd0);
    $display("op 0x%04h / 0x%02h -> q=0x%02h r=0x%02h div0=%0b ovf=%0b after %0d edges",
             v.dividend, v.divisor, quotient_o, remainder_o, div0_o, ovf_o, edges);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("valid_after_take", 32'(out_valid_o), 32'd0);
    check("ready_after_take", 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [7:0] hold_q, hold_r;

    vecs[0] = '{16'h1392, 8'h7A, 8'h29, 8'h08, 1'b0, 1'b0, 9};
    vecs[1] = '{16'h1234, 8'h34, 8'h59, 8'h20, 1'b0, 1'b0, 9};
    vecs[2] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
    vecs[3] = '{16'h00AB, 8'h00, 8'hFF, 8'hAB, 1'b1, 1'b0, 1};
    vecs[4] = '{16'h8000, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[5] = '{16'h0220, 8'h20, 8'h11, 8'h00, 1'b0, 1'b0, 9};

    // Reset with a pending request: reset must win.
    rst_i       = 1'b1;
    in_valid_i  = 1'b1;
    dividend_i  = 16'h00AB;
    divisor_i   = 8'h00;
    out_ready_i = 1'b0;
    tick();
    tick();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_quotient", 32'(quotient_o), 32'd0);
    check("rst_remainder", 32'(remainder_o), 32'd0);
    check("rst_div0", 32'(div0_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i]);
    end

    // Backpressure with in_valid toggling outside IDLE, then back-to-back op.
    in_valid_i = 1'b1;
    dividend_i = 16'h1392;
    divisor_i  = 8'h7A;
    tick();
    dividend_i = 16'hFFFF;
    divisor_i  = 8'h01;
    for (int i = 0; i < 20 && !out_valid_o; i++) tick();
    check("bp_valid", 32'(out_valid_o), 32'd1);
    hold_q = quotient_o;
    hold_r = remainder_o;
    check("bp_quotient", 32'(hold_q), 32'h29);
    check("bp_remainder", 32'(hold_r), 32'h08);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid_o), 32'd1);
      check("bp_hold_ready", 32'(in_ready_o), 32'd0);
      check("bp_hold_q", 32'(quotient_o), 32'h29);
      check("bp_hold_r", 32'(remainder_o), 32'h08);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    check("bp_release_ready", 32'(in_ready_o), 32'd1);
    $display("backpressure hold of 5 cycles on q=0x%02h r=0x%02h released", hold_q, hold_r);
    do_op(vecs[5]);

    // Reset in the middle of an iteration sequence.
    in_valid_i = 1'b1;
    dividend_i = 16'h1234;
    divisor_i  = 8'h34;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_in_ready", 32'(in_ready_o), 32'd1);
    check("midrst_out_valid", 32'(out_valid_o), 32'd0);
    check("midrst_quotient", 32'(quotient_o), 32'd0);
    check("midrst_remainder", 32'(remainder_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_no_result", 32'(out_valid_o), 32'd0);
    end
    $display("reset mid-run abandoned 0x1234 / 0x34");
    v = '{16'h4400, 8'h44, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    do_op(v);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
